// File: rtl/vx_ti_bvh_traverse_if.sv
// Handshake and operand bundle for the per-ray BVH traversal controller.
// master = traversal controller, slave = surrounding ray tracing unit.
`ifndef TI_FLOAT_BITS
`define TI_FLOAT_BITS 32
`endif

interface vx_ti_bvh_traverse_if #(
  parameter int NODE_BITS = 24,
  parameter int TAG_BITS  = 8
);
  localparam int FB = `TI_FLOAT_BITS;

  // ray request
  logic                 req_valid;
  logic                 req_ready;
  logic [3*FB-1:0]      req_ray_origin;
  logic [3*FB-1:0]      req_ray_dir;
  logic [FB-1:0]        req_ray_t;
  logic [NODE_BITS-1:0] req_root;
  logic [TAG_BITS-1:0]  req_tag;

  // node memory
  logic                 mem_req_valid;
  logic                 mem_req_ready;
  logic [NODE_BITS-1:0] mem_req_node;
  logic                 mem_rsp_valid;
  logic [3*FB-1:0]      mem_rsp_bmin;
  logic [3*FB-1:0]      mem_rsp_bmax;
  logic [NODE_BITS-1:0] mem_rsp_left;
  logic [15:0]          mem_rsp_count;

  // box intersection stage
  logic                 box_enable;
  logic [3*FB-1:0]      box_bmin;
  logic [3*FB-1:0]      box_bmax;
  logic [3*FB-1:0]      box_ray_origin;
  logic [3*FB-1:0]      box_ray_dir;
  logic [FB-1:0]        box_ray_t;
  logic                 box_intersect;

  // leaf output
  logic                 leaf_valid;
  logic                 leaf_ready;
  logic [NODE_BITS-1:0] leaf_first;
  logic [15:0]          leaf_count;
  logic [TAG_BITS-1:0]  leaf_tag;

  // completion
  logic                 done_valid;
  logic                 done_ready;
  logic [TAG_BITS-1:0]  done_tag;
  logic                 done_overflow;

  logic                 busy;

  modport master (
    input  req_valid, req_ray_origin, req_ray_dir, req_ray_t, req_root, req_tag,
    output req_ready,
    output mem_req_valid, mem_req_node,
    input  mem_req_ready,
    input  mem_rsp_valid, mem_rsp_bmin, mem_rsp_bmax, mem_rsp_left, mem_rsp_count,
    output box_enable, box_bmin, box_bmax, box_ray_origin, box_ray_dir, box_ray_t,
    input  box_intersect,
    output leaf_valid, leaf_first, leaf_count, leaf_tag,
    input  leaf_ready,
    output done_valid, done_tag, done_overflow,
    input  done_ready,
    output busy
  );

  modport slave (
    output req_valid, req_ray_origin, req_ray_dir, req_ray_t, req_root, req_tag,
    input  req_ready,
    input  mem_req_valid, mem_req_node,
    output mem_req_ready,
    output mem_rsp_valid, mem_rsp_bmin, mem_rsp_bmax, mem_rsp_left, mem_rsp_count,
    input  box_enable, box_bmin, box_bmax, box_ray_origin, box_ray_dir, box_ray_t,
    output box_intersect,
    input  leaf_valid, leaf_first, leaf_count, leaf_tag,
    output leaf_ready,
    input  done_valid, done_tag, done_overflow,
    output done_ready,
    input  busy
  );
endinterface

// File: rtl/vx_ti_bvh_traverse.sv
// Per-ray depth-first BVH traversal controller. Holds one ray, walks the tree
// with a node-index stack, drives the box test, emits hit leaves and a
// completion token. All outputs are decodes of the registered state.
`ifndef TI_FLOAT_BITS
`define TI_FLOAT_BITS 32
`endif

module vx_ti_bvh_traverse #(
  parameter int STACK_DEPTH = 16,
  parameter int NODE_BITS   = 24,
  parameter int TAG_BITS    = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  vx_ti_bvh_traverse_if.master   bus
);
  localparam int FB      = `TI_FLOAT_BITS;
  localparam int SP_BITS = $clog2(STACK_DEPTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_TEST, S_LEAF, S_POP, S_DONE
  } state_t;

  state_t               r_state;
  logic [3*FB-1:0]      r_origin;
  logic [3*FB-1:0]      r_dir;
  logic [FB-1:0]        r_t;
  logic [TAG_BITS-1:0]  r_tag;
  logic [NODE_BITS-1:0] r_cur;
  logic [SP_BITS-1:0]   r_sp;
  logic                 r_ovf;
  logic [3*FB-1:0]      r_bmin;
  logic [3*FB-1:0]      r_bmax;
  logic [NODE_BITS-1:0] r_left;
  logic [15:0]          r_count;
  logic [NODE_BITS-1:0] r_stack [STACK_DEPTH];

  logic                 w_test;
  logic                 w_descend;
  logic                 w_push_ok;
  logic [NODE_BITS-1:0] w_left_inc;
  logic [SP_BITS-1:0]   w_sp_dec;

  assign w_test     = (r_state == S_TEST);
  // hit on an interior node: descend into left child, remember the right one
  assign w_descend  = w_test && bus.box_intersect && (r_count == '0);
  // a full stack drops the push; the left child is still visited
  assign w_push_ok  = w_descend && (r_sp != SP_BITS'(STACK_DEPTH));
  // wraps modulo 2^NODE_BITS on purpose
  assign w_left_inc = r_left + NODE_BITS'(1);
  assign w_sp_dec   = r_sp - SP_BITS'(1);

  // stack storage: no reset needed, sp alone defines which entries are live
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_stack[r_sp[SP_BITS-2:0]] <= w_left_inc;
    end
  end

  // traversal FSM and per-ray context
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_origin <= '0;
      r_dir    <= '0;
      r_t      <= '0;
      r_tag    <= '0;
      r_cur    <= '0;
      r_sp     <= '0;
      r_ovf    <= 1'b0;
      r_bmin   <= '0;
      r_bmax   <= '0;
      r_left   <= '0;
      r_count  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_origin <= bus.req_ray_origin;
            r_dir    <= bus.req_ray_dir;
            r_t      <= bus.req_ray_t;
            r_tag    <= bus.req_tag;
            r_cur    <= bus.req_root;
            r_sp     <= '0;
            r_ovf    <= 1'b0;
            r_state  <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (bus.mem_req_ready) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.mem_rsp_valid) begin
            r_bmin  <= bus.mem_rsp_bmin;
            r_bmax  <= bus.mem_rsp_bmax;
            r_left  <= bus.mem_rsp_left;
            r_count <= bus.mem_rsp_count;
            r_state <= S_TEST;
          end
        end
        S_TEST: begin
          if (!bus.box_intersect) begin
            r_state <= S_POP;
          end else if (r_count != '0) begin
            r_state <= S_LEAF;
          end else begin
            r_cur <= r_left;
            if (w_push_ok) begin
              r_sp <= r_sp + SP_BITS'(1);
            end else begin
              r_ovf <= 1'b1;
            end
            r_state <= S_FETCH;
          end
        end
        S_LEAF: begin
          if (bus.leaf_ready) begin
            r_state <= S_POP;
          end
        end
        S_POP: begin
          if (r_sp == '0) begin
            r_state <= S_DONE;
          end else begin
            r_sp    <= w_sp_dec;
            r_cur   <= r_stack[w_sp_dec[SP_BITS-2:0]];
            r_state <= S_FETCH;
          end
        end
        S_DONE: begin
          if (bus.done_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready      = (r_state == S_IDLE);
  assign bus.busy           = (r_state != S_IDLE);

  assign bus.mem_req_valid  = (r_state == S_FETCH);
  assign bus.mem_req_node   = (r_state == S_FETCH) ? r_cur : '0;

  assign bus.box_enable     = w_test;
  assign bus.box_bmin       = w_test ? r_bmin   : '0;
  assign bus.box_bmax       = w_test ? r_bmax   : '0;
  assign bus.box_ray_origin = w_test ? r_origin : '0;
  assign bus.box_ray_dir    = w_test ? r_dir    : '0;
  assign bus.box_ray_t      = w_test ? r_t      : '0;

  assign bus.leaf_valid     = (r_state == S_LEAF);
  assign bus.leaf_first     = (r_state == S_LEAF) ? r_left  : '0;
  assign bus.leaf_count     = (r_state == S_LEAF) ? r_count : '0;
  assign bus.leaf_tag       = (r_state == S_LEAF) ? r_tag   : '0;

  assign bus.done_valid     = (r_state == S_DONE);
  assign bus.done_tag       = (r_state == S_DONE) ? r_tag : '0;
  assign bus.done_overflow  = (r_state == S_DONE) && r_ovf;

endmodule

// File: doc/vx_ti_bvh_traverse.md
# vx_ti_bvh_traverse

Per-ray BVH traversal controller for the ray tracing unit. It accepts one ray at a time and walks the BVH depth-first using a node-index stack. It fetches each node from node memory and drives the axis-aligned bounding-box intersection stage with that node's bounds and the held ray. Leaf nodes whose box is hit are emitted to the triangle stage; a completion token is emitted when the stack drains.

## Interface
- STACK_DEPTH, 16, node-index stack entries (power of two, ≥2)
- NODE_BITS, 24, node index width
- TAG_BITS, 8, ray tag width
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- req_valid / req_ready  in / out  1  ray request handshake
- req_ray_origin, req_ray_dir  in  3*`TI_FLOAT_BITS  ray origin/direction, X at [31:0], Y [63:32], Z [95:64]
- req_ray_t  in  `TI_FLOAT_BITS  ray max distance
- req_root  in  NODE_BITS  root node index
- req_tag  in  TAG_BITS  ray tag
- mem_req_valid / mem_req_ready  out / in  1  node fetch handshake
- mem_req_node  out  NODE_BITS  node index to fetch
- mem_rsp_valid  in  1  node data valid (no backpressure)
- mem_rsp_bmin, mem_rsp_bmax  in  3*`TI_FLOAT_BITS  node bounds
- mem_rsp_left  in  NODE_BITS  left child index (interior) or first primitive (leaf)
- mem_rsp_count  in  16  primitive count; 0 = interior node
- box_enable  out  1  box test strobe
- box_bmin, box_bmax, box_ray_origin, box_ray_dir  out  3*`TI_FLOAT_BITS  box test operands
- box_ray_t  out  `TI_FLOAT_BITS  box test ray_t
- box_intersect  in  1  combinational hit result, valid in the cycle box_enable=1
- leaf_valid / leaf_ready  out / in  1  leaf output handshake
- leaf_first  out  NODE_BITS  first primitive; leaf_count  out  16; leaf_tag  out  TAG_BITS
- done_valid / done_ready  out / in  1  ray completion handshake
- done_tag  out  TAG_BITS; done_overflow  out  1  stack overflowed during this ray
- busy  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, FETCH, WAIT, TEST, LEAF, POP, DONE.
- IDLE: req_ready=1. On req_valid, latch ray, tag and root. Set cur=root, sp=0, ovf=0. Go to FETCH.
- FETCH: mem_req_valid=1, mem_req_node=cur. On mem_req_ready, go to WAIT.
- WAIT: on mem_rsp_valid, latch bounds/left/count and go to TEST. mem_rsp_valid in any other state is ignored.
- TEST: box_enable=1 for exactly one cycle; operands come from latched registers and are stable during the cycle.
  - Miss: go to POP.
  - Hit, count≠0: go to LEAF.
  - Hit, count=0: push left+1 and set cur=left. Go to FETCH.
- Push when sp==STACK_DEPTH: the push is dropped and ovf is set (sticky for the ray). The left child is still fetched.
- LEAF: leaf_valid=1 holding first/count/tag until leaf_ready, then go to POP.
- POP: if sp==0, go to DONE. Otherwise sp−1, cur=stack[sp−1], go to FETCH.
- DONE: done_valid=1, done_tag, done_overflow=ovf until done_ready, then go to IDLE.
- Child index arithmetic is modulo 2^NODE_BITS (left=all-ones wraps left+1 to 0). No error is flagged.
- box_* operand outputs are 0 while box_enable=0.

## Timing
- Reset (async assert, sync-safe deassert) forces IDLE, sp=0, ovf=0. Every output is 0 except req_ready, which is 1 in IDLE.
- Reset mid-ray discards the ray. No leaf or done token is produced for it.
- Valid/data outputs are registered-state decodes: they stay stable until their handshake completes and never drop without ready.
- Per node with zero-wait memory (ready and rsp on first cycle each): FETCH 1 + WAIT 1 + TEST 1 = 3 cycles.
  - Miss adds POP 1.
  - Leaf adds 1 + leaf stall cycles, then POP 1.
- Request accept to first mem_req_valid is 1 cycle. POP with empty stack to done_valid is 1 cycle. done handshake to req_ready is 1 cycle.
- Only one ray is in flight; req_ready=0 from the accept cycle until return to IDLE.

## Test plan
- Single leaf root (count=3, first=40), box_intersect=1 → one leaf (first=40,count=3,tag) then done_overflow=0; zero-wait path takes 6 cycles from accept to done_valid.
- Root miss (box_intersect=0) → no leaf, done_valid 5 cycles after accept, mem_req count=1.
- Two-level tree: root interior left=1, nodes 1,2 leaves, all hits → fetch order 0,1,2; leaves from 1 then 2; done; sp ends 0.
- Degenerate left-spine depth 20 with STACK_DEPTH=16, all hits → 16 pushes kept, 4 dropped, done_overflow=1; next ray shows done_overflow=0.
- Backpressure: mem_req_ready low 5 cycles, leaf_ready low 7, done_ready low 3 → outputs held stable, no duplicate fetches, leaves or tokens.
- Assert reset_n low while in WAIT with leaf pending → all outputs 0 immediately, req_ready=1 after release, stale mem_rsp_valid ignored, fresh ray completes correctly.
